// File: rtl/fft_pkg.sv
// Shared FFT definitions: serializer state encoding, index-width helper and
// the bit-reversal function also used by the FFT input reorder stage.
package fft_pkg;

  typedef enum logic {IDLE, STREAM} ser_state_t;

  // Width of a bin index; a 2-point frame still needs one index bit.
  function automatic int idx_bits(input int samples);
    return (samples > 2) ? $clog2(samples) : 1;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// Captures a full FFT output frame in one handshake and streams the bins out
// one per beat, in natural or bit-reversed order, tagged with index and last.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int SAMPLES     = 16,
  parameter int WIDTH       = 32,
  parameter int BIT_REVERSE = 0,
  localparam int IW         = idx_bits(SAMPLES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  input  logic [SAMPLES-1:0][WIDTH-1:0]   frame_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [IW-1:0]                   out_index,
  output logic                            out_last
);

  localparam logic [IW-1:0] LAST_CNT = IW'(SAMPLES - 1);

  if (SAMPLES < 2 || (SAMPLES & (SAMPLES - 1)) != 0) begin : g_bad_samples
    $error("fft_frame_serializer: SAMPLES must be a power of two and >= 2");
  end

  ser_state_t                   state_q, state_d;
  logic [IW-1:0]                cnt_q, cnt_d;
  logic [SAMPLES-1:0][WIDTH-1:0] buf_q, buf_d;
  logic                         capture;
  logic [IW-1:0]                rd_idx;

  // Handshake flags come straight from the state register, so no input
  // can combinationally reach frame_ready or out_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    frame_ready = (state_q == IDLE);
    out_valid   = (state_q == STREAM);
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    buf_d = capture ? frame_data : buf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bin storage carries no reset: its contents only matter once captured.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    rd_idx    = (BIT_REVERSE != 0) ? IW'(bitrev(32'(cnt_q), IW)) : cnt_q;
    out_index = out_valid ? rd_idx : '0;
    out_data  = out_valid ? buf_q[rd_idx] : '0;
    out_last  = out_valid && (cnt_q == LAST_CNT);
  end

endmodule
